t03_register_file_gen: RTL and testbench
========================================

T03_REGISTER_FILE_GEN -- requirements
Module: t03_register_file_gen

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning register count; AW = $clog2(NUM_REGS).
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of independent read ports.
REQ-004 The block SHALL have parameter PROT_N, default 3, meaning count of top registers that are read-only.
REQ-005 The block SHALL have parameter PROT_INIT, default {32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFC}, meaning the reset values of registers NUM_REGS-1 down to NUM_REGS-PROT_N.

Ports:
REQ-006 The block SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-007 The block SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port en, input, 1, global stall; when low, all state SHALL hold.
REQ-009 The block SHALL have port rd_addr, input, NUM_RD*AW, packed read addresses; port k uses slice k.
REQ-010 The block SHALL have port rd_data, output, NUM_RD*DATA_W, packed combinational read data.
REQ-011 The block SHALL have port wr_en, input, 1, write request.
REQ-012 The block SHALL have port wr_addr, input, AW, write address.
REQ-013 The block SHALL have port wr_be, input, DATA_W/8, byte enables.
REQ-014 The block SHALL have port wr_data, input, DATA_W, write data.
REQ-015 The block SHALL have port clr_start, input, 1, one-cycle request to zero all writable registers.
REQ-016 The block SHALL have port busy, output, 1, high while the clear sequence runs.
REQ-017 The block SHALL have port clr_done, output, 1, one-cycle pulse on the final clear cycle.
REQ-018 The block SHALL have port wr_drop, output, 1, high in any cycle where wr_en is high but the write is discarded.

Function
REQ-019 A write SHALL be effective iff en & wr_en & ~busy & wr_addr != 0 & wr_addr < NUM_REGS-PROT_N.
REQ-020 An effective write SHALL update only the bytes selected by wr_be at the next rising edge; unselected bytes SHALL hold.
REQ-021 Register 0 SHALL always read 0, and the protected registers SHALL always read their PROT_INIT value.
REQ-022 Each read port SHALL return the stored value of its address combinationally, with zero cycles of latency.
REQ-023 Bypass: when a write is effective and rd_addr[k] == wr_addr, rd_data[k] SHALL show the byte-merged post-write value in that same cycle.
REQ-024 Address values >= NUM_REGS (non-power-of-2 NUM_REGS) SHALL read 0, and writes to them SHALL be dropped.
REQ-025 wr_drop SHALL equal en & wr_en & ~(effective write).
REQ-026 The FSM SHALL have states IDLE and CLEAR; the reset state SHALL be IDLE.
REQ-027 IDLE -> CLEAR SHALL occur on en & clr_start; the clear pointer SHALL load 1.
REQ-028 In CLEAR with en high, the pointed register SHALL be zeroed each cycle and the pointer SHALL increment.
REQ-029 When the pointer equals NUM_REGS-PROT_N-1, that register SHALL be zeroed, clr_done SHALL be high in that cycle, and the next state SHALL be IDLE.
REQ-030 Clear latency SHALL be NUM_REGS-PROT_N-1 enabled cycles (28 with the defaults).
REQ-031 In CLEAR, en low SHALL freeze the pointer and state; clr_done SHALL not assert while en is low.
REQ-032 busy SHALL be high iff state == CLEAR.
REQ-033 clr_start while busy SHALL be ignored.
REQ-034 A write in the same cycle as clr_start in IDLE SHALL be effective, because busy is still low; the clear then overwrites it.
REQ-035 Reads during CLEAR SHALL return current contents: already-cleared registers read 0, and no bypass applies.
REQ-036 Widths: DATA_W SHALL be a multiple of 8, 1 <= PROT_N <= NUM_REGS-2, and NUM_RD >= 1; the block SHALL check these by elaboration assertion.

Reset
REQ-037 nrst low SHALL, asynchronously: zero registers 0..NUM_REGS-PROT_N-1, load PROT_INIT into the protected registers, set the state to IDLE, zero the pointer, and drive busy=0, clr_done=0.
REQ-038 Reset asserted mid-CLEAR SHALL abort the sequence, with the reset values applied immediately.
REQ-039 Deassertion SHALL take effect at the first rising edge after nrst goes high; no outputs SHALL glitch beyond the combinational read paths.

Verification
REQ-040 Scenario, reset and protected registers: after reset -> rd_addr 31/30/29 read FFFFFFFF/FFFFFFFD/FFFFFFFC, and addr 5 reads 0.
REQ-041 Scenario, byte-enable write with bypass: reg5 = 0; write 5, be=4'b0101, data=AABBCCDD -> same-cycle read 5 = 00BB00DD, next-cycle read 5 = 00BB00DD.
REQ-042 Scenario, dropped writes: writes to 0, 30, and a write with en=0 -> wr_drop=1 in each case except en=0 (wr_drop=0), and contents are unchanged.
REQ-043 Scenario, clear sequence: fill regs 1..28 with nonzero values, pulse clr_start -> busy high for 28 cycles, clr_done on cycle 28, then all read 0 and 29..31 are unchanged.
REQ-044 Scenario, clear stall: hold en low for 5 cycles mid-CLEAR -> busy stays high, the pointer holds, and total busy equals 33 cycles.
REQ-045 Scenario, reset abort: assert nrst at cycle 10 of CLEAR -> busy=0 immediately, all writable registers read 0, and the protected values are restored.

Source files
------------

// File: rtl/t03_register_file_gen_if.sv
// ----------------------------------------------------------------------------
// t03_register_file_gen_if
// Bus bundle for the register file: read ports, byte-enabled write port,
// clear-sequence control and status.
//
// Signals (direction as seen by the register file, modport slave):
//   en        in   global stall, all state holds while low
//   rd_addr   in   NUM_RD packed read addresses, port k uses slice k
//   rd_data   out  NUM_RD packed combinational read data
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_be     in   write byte enables
//   wr_data   in   write data
//   clr_start in   one-cycle request to zero all writable registers
//   busy      out  high while the clear sequence runs
//   clr_done  out  pulse on the final clear cycle
//   wr_drop   out  write requested but discarded
// ----------------------------------------------------------------------------
interface t03_register_file_gen_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned AW   = $clog2(NUM_REGS);
    localparam int unsigned BE_W = DATA_W / 8;

    logic                     en;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [BE_W-1:0]          wr_be;
    logic [DATA_W-1:0]        wr_data;
    logic                     clr_start;
    logic                     busy;
    logic                     clr_done;
    logic                     wr_drop;

    modport master (
        output en, rd_addr, wr_en, wr_addr, wr_be, wr_data, clr_start,
        input  rd_data, busy, clr_done, wr_drop
    );

    modport slave (
        input  en, rd_addr, wr_en, wr_addr, wr_be, wr_data, clr_start,
        output rd_data, busy, clr_done, wr_drop
    );
endinterface

// File: rtl/t03_register_file_gen.sv
// ----------------------------------------------------------------------------
// t03_register_file_gen
// Multi-read-port register file with one byte-enabled write port, a hardwired
// zero register 0, PROT_N read-only registers at the top of the address map,
// write-to-read bypass and a sequenced clear of all writable registers.
//
// Ports:
//   clk   in  system clock, rising edge
//   nrst  in  asynchronous active-low reset
//   bus   t03_register_file_gen_if.slave (see interface file for signals)
// ----------------------------------------------------------------------------
module t03_register_file_gen #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned PROT_N   = 3,
    parameter logic [PROT_N*DATA_W-1:0] PROT_INIT =
        {32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFC}
) (
    input  logic                          clk,
    input  logic                          nrst,
    t03_register_file_gen_if.slave        bus
);
    localparam int unsigned AW   = $clog2(NUM_REGS);
    localparam int unsigned BE_W = DATA_W / 8;
    // Registers 0..WR_N-1 are stored; 0 is never written and always reads 0.
    localparam int unsigned WR_N = NUM_REGS - PROT_N;

    localparam logic [AW:0]   NR_W     = (AW + 1)'(NUM_REGS);
    localparam logic [AW:0]   WR_N_W   = (AW + 1)'(WR_N);
    localparam logic [AW-1:0] CLR_LAST = AW'(WR_N - 1);

    if (DATA_W % 8 != 0) begin : g_chk_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (PROT_N < 1 || PROT_N + 2 > NUM_REGS) begin : g_chk_prot_n
        $error("PROT_N must satisfy 1 <= PROT_N <= NUM_REGS-2");
    end
    if (NUM_RD < 1) begin : g_chk_num_rd
        $error("NUM_RD must be at least 1");
    end

    typedef enum logic {StIdle, StClear} state_e;

    state_e            r_state;
    logic [AW-1:0]     r_ptr;
    logic [DATA_W-1:0] r_regs [WR_N];

    logic [DATA_W-1:0]        w_view [NUM_REGS];
    logic                     w_busy;
    logic                     w_last;
    logic                     w_wr_eff;
    logic [DATA_W-1:0]        w_wr_old;
    logic [DATA_W-1:0]        w_wr_merged;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;

    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_v,
                                                  input logic [DATA_W-1:0] new_v,
                                                  input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Architectural view of every address: zero reg, stored regs, constants.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
        if (i == 0) begin : g_zero
            assign w_view[i] = '0;
        end else if (i < WR_N) begin : g_stored
            assign w_view[i] = r_regs[i];
        end else begin : g_prot
            assign w_view[i] = PROT_INIT[(i - WR_N)*DATA_W +: DATA_W];
        end
    end

    assign w_busy = (r_state == StClear);
    assign w_last = (r_ptr == CLR_LAST);

    assign w_wr_eff = bus.en && bus.wr_en && !w_busy && (bus.wr_addr != '0) &&
                      ({1'b0, bus.wr_addr} < WR_N_W);

    always_comb begin
        w_wr_old = '0;
        if ({1'b0, bus.wr_addr} < WR_N_W) begin
            w_wr_old = r_regs[bus.wr_addr];
        end
    end

    assign w_wr_merged = f_merge(w_wr_old, bus.wr_data, bus.wr_be);

    // Read ports; bypass only applies to writes that will actually land.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = bus.rd_addr[k*AW +: AW];

        always_comb begin
            w_data = '0;
            if ({1'b0, w_addr} < NR_W) begin
                w_data = w_view[w_addr];
            end
            if (w_wr_eff && (w_addr == bus.wr_addr)) begin
                w_data = w_wr_merged;
            end
        end

        assign w_rd_data[k*DATA_W +: DATA_W] = w_data;
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.busy     = w_busy;
    assign bus.clr_done = w_busy && bus.en && w_last;
    assign bus.wr_drop  = bus.en && bus.wr_en && !w_wr_eff;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < WR_N; i++) begin
                r_regs[i] <= '0;
            end
            r_state <= StIdle;
            r_ptr   <= '0;
        end else if (bus.en) begin
            if (w_wr_eff) begin
                r_regs[bus.wr_addr] <= w_wr_merged;
            end
            unique case (r_state)
                StIdle: begin
                    // A same-cycle write still lands; the clear wipes it later.
                    if (bus.clr_start) begin
                        r_state <= StClear;
                        r_ptr   <= AW'(1);
                    end
                end
                StClear: begin
                    r_regs[r_ptr] <= '0;
                    if (w_last) begin
                        r_state <= StIdle;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_t03_register_file_gen.sv
// ----------------------------------------------------------------------------
// tb_t03_register_file_gen
// Self-checking bench for t03_register_file_gen with default parameters.
// A behavioural model (array of register values plus "next register to wipe")
// is compared against the DUT every cycle; directed steps add literal checks.
// ----------------------------------------------------------------------------
module tb_t03_register_file_gen;
    logic clk;
    logic nrst;

    int checks   = 0;
    int failures = 0;

    t03_register_file_gen_if bus ();

    t03_register_file_gen dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [31:0] m_regs [32];
    int          m_next;   // next register the clear will wipe, 0 when idle

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 29; i++) m_regs[i] = 32'h0;
        m_regs[29] = 32'hFFFFFFFC;
        m_regs[30] = 32'hFFFFFFFD;
        m_regs[31] = 32'hFFFFFFFF;
        m_next = 0;
    endtask

    initial begin
        bit m_busy;
        bit m_eff;
        int wa;
        int ra;
        logic [31:0] v;
        model_reset();
        forever begin
            @(negedge clk);
            #2;
            if (!nrst) model_reset();
            m_busy = (m_next != 0);
            wa     = int'(bus.wr_addr);
            m_eff  = bus.en && bus.wr_en && !m_busy && wa != 0 && wa < 29;
            chk("cmp busy", bus.busy, m_busy);
            chk("cmp clr_done", bus.clr_done, m_busy && bus.en && m_next == 28);
            chk("cmp wr_drop", bus.wr_drop, bus.en && bus.wr_en && !m_eff);
            for (int k = 0; k < 2; k++) begin
                ra = int'(bus.rd_addr[k*5 +: 5]);
                v  = m_regs[ra];
                if (m_eff && ra == wa) v = merge(v, bus.wr_data, bus.wr_be);
                chk($sformatf("cmp rd%0d addr%0d", k, ra), bus.rd_data[k*32 +: 32], v);
            end
            @(posedge clk);
            if (!nrst) begin
                model_reset();
            end else if (bus.en) begin
                if (m_eff) m_regs[wa] = merge(m_regs[wa], bus.wr_data, bus.wr_be);
                if (m_next != 0) begin
                    m_regs[m_next] = 32'h0;
                    m_next = (m_next == 28) ? 0 : m_next + 1;
                end else if (bus.clr_start) begin
                    m_next = 1;
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic set_rd(input int a0, input int a1);
        bus.rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic wr(input int a, input logic [3:0] be, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(a);
        bus.wr_be   = be;
        bus.wr_data = d;
    endtask

    task automatic idle_in();
        bus.en        = 1'b1;
        bus.wr_en     = 1'b0;
        bus.clr_start = 1'b0;
    endtask

    // Runs after clr_start was applied; counts busy cycles and the clr_done cycle.
    task automatic run_clear(input int stall_at, input int stall_len,
                             output int n_busy, output int done_at);
        n_busy  = 0;
        done_at = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            idle_in();
            bus.en = !(stall_at >= 0 && c >= stall_at && c < stall_at + stall_len);
            set_rd($urandom_range(0, 31), $urandom_range(1, 28));
            if (c == 3) begin
                bus.clr_start = 1'b1;
                wr(4, 4'hF, 32'h5A5A5A5A);
            end
            #2;
            if (!bus.busy) break;
            n_busy++;
            if (bus.clr_done) done_at = n_busy;
        end
    endtask

    initial begin
        int nb;
        int dn;
        logic [31:0] prot [3];
        prot[0] = 32'hFFFFFFFC;
        prot[1] = 32'hFFFFFFFD;
        prot[2] = 32'hFFFFFFFF;

        nrst = 1'b0;
        idle_in();
        bus.wr_addr = '0;
        bus.wr_be   = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        // Reset state and protected registers
        @(negedge clk);
        set_rd(31, 30);
        #2;
        chk("rst r31", bus.rd_data[31:0], 32'hFFFFFFFF);
        chk("rst r30", bus.rd_data[63:32], 32'hFFFFFFFD);
        chk("rst busy", bus.busy, 1'b0);
        @(negedge clk);
        set_rd(29, 5);
        #2;
        chk("rst r29", bus.rd_data[31:0], 32'hFFFFFFFC);
        chk("rst r5", bus.rd_data[63:32], 32'h0);

        // Byte-enable write with bypass
        @(negedge clk);
        wr(5, 4'b0101, 32'hAABBCCDD);
        set_rd(5, 5);
        #2;
        chk("byp same cycle", bus.rd_data[31:0], 32'h00BB00DD);
        chk("byp wr_drop", bus.wr_drop, 1'b0);
        @(negedge clk);
        bus.wr_en = 1'b0;
        #2;
        chk("byp next cycle", bus.rd_data[31:0], 32'h00BB00DD);
        @(negedge clk);
        wr(5, 4'b1010, 32'h11223344);
        set_rd(5, 6);
        #2;
        chk("byp upper bytes", bus.rd_data[31:0], 32'h11BB33DD);
        chk("byp other port", bus.rd_data[63:32], 32'h0);

        // Dropped writes
        @(negedge clk);
        wr(0, 4'hF, 32'hFFFFFFFF);
        set_rd(0, 5);
        #2;
        chk("drop addr0", bus.wr_drop, 1'b1);
        chk("drop addr0 rd", bus.rd_data[31:0], 32'h0);
        @(negedge clk);
        wr(30, 4'hF, 32'h0);
        set_rd(30, 5);
        #2;
        chk("drop addr30", bus.wr_drop, 1'b1);
        chk("drop addr30 rd", bus.rd_data[31:0], 32'hFFFFFFFD);
        @(negedge clk);
        bus.en = 1'b0;
        wr(5, 4'hF, 32'h0);
        #2;
        chk("drop en0", bus.wr_drop, 1'b0);
        chk("drop en0 rd", bus.rd_data[63:32], 32'h11BB33DD);
        @(negedge clk);
        idle_in();
        set_rd(0, 5);
        #2;
        chk("drop after r0", bus.rd_data[31:0], 32'h0);
        chk("drop after r5", bus.rd_data[63:32], 32'h11BB33DD);

        // Mixed random traffic, checked by the model
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            bus.en = ($urandom_range(0, 3) != 0);
            wr($urandom_range(0, 31), 4'($urandom), $urandom);
            bus.wr_en = ($urandom_range(0, 3) != 0);
            set_rd($urandom_range(0, 31), int'(bus.wr_addr));
        end

        // Fill 1..28 with nonzero values, then clear
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            idle_in();
            wr(i, 4'hF, $urandom | 32'h1);
            set_rd(i, $urandom_range(0, 31));
        end
        @(negedge clk);
        idle_in();
        bus.clr_start = 1'b1;
        set_rd(1, 28);
        #2;
        chk("clr start busy", bus.busy, 1'b0);
        run_clear(-1, 0, nb, dn);
        chk("clr busy cycles", nb, 28);
        chk("clr done cycle", dn, 28);
        for (int a = 1; a <= 31; a++) begin
            @(negedge clk);
            idle_in();
            set_rd(a, 0);
            #2;
            chk($sformatf("clr after r%0d", a), bus.rd_data[31:0],
                (a >= 29) ? prot[a - 29] : 32'h0);
        end

        // Write in the start cycle lands, then a stalled clear wipes it
        @(negedge clk);
        wr(15, 4'hF, 32'h0F0F0F0F);
        @(negedge clk);
        idle_in();
        bus.clr_start = 1'b1;
        wr(7, 4'hF, 32'h12345678);
        set_rd(7, 15);
        #2;
        chk("start+wr bypass", bus.rd_data[31:0], 32'h12345678);
        chk("start+wr drop", bus.wr_drop, 1'b0);
        run_clear(10, 5, nb, dn);
        chk("stall busy cycles", nb, 33);
        chk("stall done cycle", dn, 33);
        @(negedge clk);
        idle_in();
        set_rd(7, 15);
        #2;
        chk("stall after r7", bus.rd_data[31:0], 32'h0);
        chk("stall after r15", bus.rd_data[63:32], 32'h0);

        // Reset abort at cycle 10 of the clear
        @(negedge clk);
        wr(20, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        idle_in();
        bus.clr_start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            idle_in();
        end
        #2;
        chk("abort pre busy", bus.busy, 1'b1);
        @(negedge clk);
        nrst = 1'b0;
        set_rd(20, 31);
        #1;
        chk("abort busy", bus.busy, 1'b0);
        chk("abort clr_done", bus.clr_done, 1'b0);
        chk("abort r20", bus.rd_data[31:0], 32'h0);
        chk("abort r31", bus.rd_data[63:32], 32'hFFFFFFFF);
        @(negedge clk);
        set_rd(30, 29);
        #2;
        chk("abort r30", bus.rd_data[31:0], 32'hFFFFFFFD);
        chk("abort r29", bus.rd_data[63:32], 32'hFFFFFFFC);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        set_rd(20, 28);
        #2;
        chk("post abort r20", bus.rd_data[31:0], 32'h0);
        chk("post abort busy", bus.busy, 1'b0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
